// File: rtl/cl_ocl_regfile_pkg.sv
// Shared types and address decode for the OCL AXI-Lite register file.
// Used by the write channel and the top level.
package cl_ocl_regfile_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  typedef struct packed {
    logic       hit_rw;
    logic       hit_ro;
    logic       err;
    logic [6:0] idx;
  } dec_t;

  // Map a byte address onto a register index, flagging misses.
  function automatic dec_t decode(
    input logic [63:0] addr,
    input logic [63:0] base,
    input logic [7:0]  n_rw,
    input logic [7:0]  n_ro,
    input logic [2:0]  sh
  );
    logic [63:0] off;
    logic [63:0] ix;
    logic [63:0] msk;
    dec_t        d;
    off = addr - base;
    ix  = off >> sh;
    msk = (64'd1 << sh) - 64'd1;
    d   = '0;
    d.idx = ix[6:0];
    if (addr < base || (off & msk) != 64'd0
        || ix >= 64'(n_rw) + 64'(n_ro))
      d.err = 1'b1;
    else if (ix < 64'(n_rw))
      d.hit_rw = 1'b1;
    else
      d.hit_ro = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/cl_ocl_regfile_wr_chan.sv
// AW/W capture and write-response FSM.
// Emits a single-cycle commit carrying index, data, strobes, error.
module cl_ocl_regfile_wr_chan
  import cl_ocl_regfile_pkg::*;
#(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h500,
  parameter int              NUM_RW    = 8,
  parameter int              NUM_RO    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  output logic                commit_o,
  output logic [6:0]          idx_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [DATA_W/8-1:0] strb_o,
  output logic                err_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SH     = $clog2(STRB_W);

  wr_state_t           state_q, state_d;
  logic                aw_held_q, aw_held_d;
  logic                w_held_q, w_held_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic                bvalid_q, bvalid_d;
  resp_t               bresp_q, bresp_d;

  logic                aw_hs;
  logic                w_hs;
  logic [ADDR_W-1:0]   addr_cur;
  dec_t                dec;

  assign awready  = !aw_held_q && state_q == W_IDLE;
  assign wready   = !w_held_q && state_q == W_IDLE;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign addr_cur = aw_held_q ? addr_q : awaddr;
  assign dec      = decode(64'(addr_cur), 64'(BASE_ADDR),
                           8'(NUM_RW), 8'(NUM_RO), 3'(SH));

  assign commit_o = state_q == W_IDLE
                 && (aw_held_q || aw_hs)
                 && (w_held_q || w_hs);
  assign idx_o    = dec.idx;
  assign data_o   = w_held_q ? data_q : wdata;
  assign strb_o   = w_held_q ? strb_q : wstrb;
  assign err_o    = !dec.hit_rw;
  assign bvalid   = bvalid_q;
  assign bresp    = bresp_q;

  // Capture halves, commit when both present, hold response to bready.
  always_comb begin
    state_d   = state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      addr_d    = awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      data_d   = wdata;
      strb_d   = wstrb;
    end
    if (commit_o) begin
      state_d  = W_RESP;
      bvalid_d = 1'b1;
      bresp_d  = dec.hit_rw ? RESP_OKAY : RESP_SLVERR;
    end
    if (state_q == W_RESP && bready) begin
      state_d   = W_IDLE;
      bvalid_d  = 1'b0;
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
    end
  end

  // Write channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

endmodule

// File: rtl/cl_ocl_regfile_axil.sv
// AXI4-Lite register file: RW control and RO status registers.
// Holds the register array, read FSM and register-0 byte swap.
module cl_ocl_regfile_axil
  import cl_ocl_regfile_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h500,
  parameter int                NUM_RW    = 8,
  parameter int                NUM_RO    = 4,
  parameter bit                SWAP_REG0 = 1'b1
) (
  input  logic                     clk_main_a0,
  input  logic                     rst_main_n,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ADDR_W-1:0]        araddr,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  input  logic [NUM_RO*DATA_W-1:0] ro_status_i,
  output logic [NUM_RW*DATA_W-1:0] rw_regs_o,
  output logic [NUM_RW-1:0]        wr_pulse_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SH     = $clog2(STRB_W);

  logic              c_commit;
  logic [6:0]        c_idx;
  logic [DATA_W-1:0] c_data;
  logic [STRB_W-1:0] c_strb;
  logic              c_err;

  logic [DATA_W-1:0] regs_q [NUM_RW];
  logic [DATA_W-1:0] regs_d [NUM_RW];
  logic [NUM_RW-1:0] pulse_q, pulse_d;

  rd_state_t         rstate_q, rstate_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  resp_t             rresp_q, rresp_d;

  logic              ar_hs;
  dec_t              rd_dec;
  logic [DATA_W-1:0] reg0_sw;
  logic [DATA_W-1:0] rd_word;

  cl_ocl_regfile_wr_chan #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .NUM_RW   (NUM_RW),
    .NUM_RO   (NUM_RO)
  ) u_wr (
    .clk     (clk_main_a0),
    .rst_n   (rst_main_n),
    .awvalid (awvalid),
    .awready (awready),
    .awaddr  (awaddr),
    .wvalid  (wvalid),
    .wready  (wready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .bvalid  (bvalid),
    .bready  (bready),
    .bresp   (bresp),
    .commit_o(c_commit),
    .idx_o   (c_idx),
    .data_o  (c_data),
    .strb_o  (c_strb),
    .err_o   (c_err)
  );

  assign arready    = rstate_q == R_IDLE;
  assign ar_hs      = arvalid && arready;
  assign rd_dec     = decode(64'(araddr), 64'(BASE_ADDR),
                             8'(NUM_RW), 8'(NUM_RO), 3'(SH));
  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign rresp      = rresp_q;
  assign wr_pulse_o = pulse_q;

  for (genvar g = 0; g < NUM_RW; g++) begin : g_out
    assign rw_regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  // Byte-strobed register update and per-register write pulse.
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (c_commit && !c_err && c_idx == 7'(i)) begin
        pulse_d[i] = 1'b1;
        for (int b = 0; b < STRB_W; b++)
          if (c_strb[b])
            regs_d[i][b*8 +: 8] = c_data[b*8 +: 8];
      end
    end
  end

  // Read data source select, including register-0 byte reversal.
  always_comb begin
    reg0_sw = '0;
    for (int b = 0; b < STRB_W; b++)
      reg0_sw[b*8 +: 8] = regs_q[0][(STRB_W-1-b)*8 +: 8];
    rd_word = '0;
    for (int i = 0; i < NUM_RW; i++)
      if (rd_dec.hit_rw && rd_dec.idx == 7'(i))
        rd_word = (SWAP_REG0 && i == 0) ? reg0_sw : regs_q[i];
    for (int k = 0; k < NUM_RO; k++)
      if (rd_dec.hit_ro && rd_dec.idx == 7'(NUM_RW + k))
        rd_word = ro_status_i[k*DATA_W +: DATA_W];
  end

  // Read FSM: register response on AR, hold until rready.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_RESP;
          rvalid_d = 1'b1;
          rdata_d  = rd_word;
          rresp_d  = rd_dec.err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_RESP: begin
        if (rready) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // Register array and read channel state.
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      for (int i = 0; i < NUM_RW; i++)
        regs_q[i] <= '0;
      pulse_q  <= '0;
      rstate_q <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      regs_q   <= regs_d;
      pulse_q  <= pulse_d;
      rstate_q <= rstate_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

endmodule

// File: tb/tb_cl_ocl_regfile_axil.sv
// Directed bench for cl_ocl_regfile_axil.
// 32-bit data, base 'h500, 8 RW and 4 RO registers, reg0 swapped.
module tb_cl_ocl_regfile_axil;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  awaddr = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [1:0]   bresp;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  araddr = '0;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic [127:0] ro_status = '0;
  logic [255:0] rw_regs;
  logic [7:0]   wr_pulse;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cl_ocl_regfile_axil dut (
    .clk_main_a0(clk),
    .rst_main_n (rst_n),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .wvalid     (wvalid),
    .wready     (wready),
    .wdata      (wdata),
    .wstrb      (wstrb),
    .bvalid     (bvalid),
    .bready     (bready),
    .bresp      (bresp),
    .arvalid    (arvalid),
    .arready    (arready),
    .araddr     (araddr),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rresp      (rresp),
    .ro_status_i(ro_status),
    .rw_regs_o  (rw_regs),
    .wr_pulse_o (wr_pulse)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single write with AW and W together; reports response and pulses.
  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input string tag,
                    input logic [1:0] exp_resp,
                    input logic [7:0] exp_pulse);
    awvalid = 1'b1; awaddr = a;
    wvalid = 1'b1; wdata = d; wstrb = s;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk({tag, " bvalid/bresp"}, {bvalid, bresp}, {1'b1, exp_resp});
    chk({tag, " pulse"}, wr_pulse, exp_pulse);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk({tag, " pulse gone"}, {bvalid, wr_pulse}, 9'd0);
  endtask

  task automatic rd(input logic [31:0] a, input string tag,
                    input logic [31:0] exp_data,
                    input logic [1:0] exp_resp);
    arvalid = 1'b1; araddr = a;
    tick();
    arvalid = 1'b0;
    chk({tag, " rvalid/rresp/rdata"}, {rvalid, rresp, rdata},
        {1'b1, exp_resp, exp_data});
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk({tag, " rvalid drop"}, {rvalid, arready}, 2'b01);
  endtask

  initial begin
    ro_status = {32'h0, 32'h0, 32'h1234_5678, 32'hCAFE_F00D};
    #23;
    chk("reset hs", {awready, wready, arready, bvalid, rvalid,
                     bresp, rresp}, 9'b111_00_00_00);
    chk("reset data", {rdata, wr_pulse}, 40'd0);
    chk("reset regs", rw_regs, 256'd0);
    rst_n = 1'b1;
    tick();

    wr(32'h504, 32'hA5A5_1234, 4'hF, "t1 wr", 2'b00, 8'h02);
    rd(32'h504, "t1 rd", 32'hA5A5_1234, 2'b00);

    wr(32'h500, 32'h1122_3344, 4'hF, "t2 wr", 2'b00, 8'h01);
    rd(32'h500, "t2 rd", 32'h4433_2211, 2'b00);
    chk("t2 reg0", rw_regs[31:0], 32'h1122_3344);

    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'b0101;
    tick();
    wvalid = 1'b0;
    chk("t3 w held", {wready, awready, bvalid}, 3'b010);
    tick();
    tick();
    awvalid = 1'b1; awaddr = 32'h508;
    tick();
    awvalid = 1'b0;
    chk("t3 bvalid/pulse", {bvalid, bresp, wr_pulse}, {3'b100, 8'h04});
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("t3 reg2", rw_regs[95:64], 32'h00FF_00FF);

    rd(32'h520, "t4 ro0", 32'hCAFE_F00D, 2'b00);
    rd(32'h524, "t4 ro1", 32'h1234_5678, 2'b00);
    rd(32'h530, "t4 past end", 32'h0, 2'b10);
    rd(32'h502, "t4 unaligned", 32'h0, 2'b10);
    rd(32'h4FC, "t4 below base", 32'h0, 2'b10);
    wr(32'h520, 32'hDEAD_BEEF, 4'hF, "t4 wr ro", 2'b10, 8'h00);
    wr(32'h500, 32'hFFFF_FFFF, 4'h0, "t4 strb0", 2'b00, 8'h01);
    chk("t4 regs", rw_regs,
        {160'd0, 32'h00FF_00FF, 32'hA5A5_1234, 32'h1122_3344});

    awvalid = 1'b1; awaddr = 32'h50C;
    wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h50C;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t5 rd old", {rvalid, rresp, rdata}, {3'b100, 32'h0});
    chk("t5 wr", {bvalid, bresp, wr_pulse}, {3'b100, 8'h08});
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    rd(32'h50C, "t5 rd new", 32'h55, 2'b00);

    awvalid = 1'b1; awaddr = 32'h510;
    wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t6 hold", {bvalid, bresp, awready, wready}, 5'b1_00_00);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 rst bvalid", {bvalid, awready, wready, wr_pulse},
        {3'b011, 8'h0});
    chk("t6 rst regs", rw_regs, 256'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("t6 after rst", {bvalid, rvalid, arready}, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
